data_reg_bank_reader: RTL
=========================

Name: data_reg_bank_reader

Overview:
- Drains the 10-entry data register bank (10 x 32-bit parallel outputs) as a word stream over a valid/ready handshake.
- On start, snapshots all bank outputs in one cycle, then emits words in ascending address order with address and last tags.
- Sits between the register bank and the downstream neuron/serial consumer. It is the read-side counterpart of the bank's address/write-all write path.

Parameters:
WIDTH, 32, data word width; must equal the bank word width.
NUM_ACTIVE, 10, number of words streamed per run, addresses 0..NUM_ACTIVE-1; legal range 1..10.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in0..in9  input  WIDTH each  bank outputs out0..out9.
start  input  1  request one drain run; sampled only in IDLE.
readyOut  input  1  consumer accepts current word.
dataOut  output  WIDTH  current word.
addrOut  output  4  bank address of current word.
validOut  output  1  dataOut/addrOut valid.
lastOut  output  1  current word is address NUM_ACTIVE-1.
busy  output  1  high from the start-accept cycle until the DONE cycle inclusive.
done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high. A single clock domain is used.
- Reset, including reset mid-run: state=IDLE; dataOut=0, addrOut=0, validOut=0, lastOut=0, busy=0, done=0. Snapshot registers and the index are cleared. Any partial run is abandoned with no done pulse.
- States: IDLE, SEND, DONE.
- IDLE: if start=1 at an edge, capture in0..in9 into snapshot registers, set idx=0, and go to SEND. busy=1 from that edge.
- SEND: validOut=1, dataOut=snap[idx], addrOut=idx, lastOut=(idx==NUM_ACTIVE-1).
  - Transfer occurs at an edge where validOut&&readyOut.
  - On a non-last transfer, idx increments and the next word appears the following cycle. Back-to-back transfers at one word per clock are allowed when readyOut is held high.
  - On the last transfer, go to DONE.
  - While readyOut=0, dataOut, addrOut and lastOut hold stable, and validOut never drops until the transfer.
- DONE: validOut=0, done=1 for exactly one cycle, busy=1, then IDLE. busy drops the cycle after DONE.
- start while in SEND or DONE is ignored and not queued.
- Snapshot isolation: bank changes (writeAll/writeAddress) after the capture edge do not affect words streamed in the current run.
- Latency:
  - start edge to first validOut: 1 cycle.
  - Minimum run length: NUM_ACTIVE+1 cycles from the start edge to done.
- NUM_ACTIVE=1: a single word is emitted with lastOut=1 immediately.
- addrOut is zero-extended idx. Addresses 10..15 are never produced.

Optional Feature:
READER_CHECKSUM_EN:
- Defined:
  - Adds output checksumOut (WIDTH), the modulo 2^WIDTH sum of all words transferred in the run.
  - The accumulator clears on the start-accept edge and adds dataOut on each transfer edge.
  - checksumOut is valid and stable from the DONE cycle until the next start accept.
  - Reset clears it to 0.
- Undefined: the port and accumulator are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst 2 cycles with start=0 -> all outputs 0, busy=0; start asserted during rst is ignored.
- Full drain: in0..in9=10..19, NUM_ACTIVE=10, pulse start, readyOut=1 -> addr 0..9 with data 10..19 on consecutive cycles; lastOut only with data 19; done pulses the next cycle; 11 cycles from start to done. With READER_CHECKSUM_EN: checksumOut=145.
- Backpressure: same inputs, readyOut toggled 0/1 each cycle -> each word held stable while readyOut=0; order 10..19 with no drops or duplicates; validOut never drops mid-run.
- Snapshot isolation: after the start edge, change in3 from 13 to 99 -> addr 3 still outputs 13. A second run then outputs 99 at addr 3.
- Ignored start and reset mid-run: pulse start again during SEND -> no restart, only one done. New run: assert rst after addr 4 is transferred -> next cycle validOut=0, busy=0, no done. A fresh start then streams from addr 0.
- NUM_ACTIVE=1, in0=0xDEADBEEF -> one word, addr 0, lastOut=1, done the next cycle.

Source files
------------

// File: rtl/data_reg_bank_reader_if.sv
// Word-stream bus from the bank reader to its downstream consumer.
// The master drives data/address/valid/last; the slave returns ready.
interface data_reg_bank_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataOut;
    logic [3:0]       addrOut;
    logic             validOut;
    logic             lastOut;
    logic             readyOut;

    modport master (
        output dataOut,
        output addrOut,
        output validOut,
        output lastOut,
        input  readyOut
    );

    modport slave (
        input  dataOut,
        input  addrOut,
        input  validOut,
        input  lastOut,
        output readyOut
    );
endinterface

// File: rtl/data_reg_bank_reader.sv
// Data register bank reader: snapshots the ten bank outputs on start and
// streams NUM_ACTIVE words (addresses 0..NUM_ACTIVE-1) over a valid/ready bus.
// Optional feature macro: READER_CHECKSUM_EN adds checksumOut, the modulo
// 2^WIDTH sum of the words transferred in the most recent run.
module data_reg_bank_reader #(
    parameter int WIDTH      = 32,
    parameter int NUM_ACTIVE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in0,
    input  logic [WIDTH-1:0]      in1,
    input  logic [WIDTH-1:0]      in2,
    input  logic [WIDTH-1:0]      in3,
    input  logic [WIDTH-1:0]      in4,
    input  logic [WIDTH-1:0]      in5,
    input  logic [WIDTH-1:0]      in6,
    input  logic [WIDTH-1:0]      in7,
    input  logic [WIDTH-1:0]      in8,
    input  logic [WIDTH-1:0]      in9,
    input  logic                  start,
    data_reg_bank_reader_if.master bus,
    output logic                  busy,
`ifdef READER_CHECKSUM_EN
    output logic [WIDTH-1:0]      checksumOut,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ACTIVE - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] snap_q [10];
    logic [WIDTH-1:0] snap_d [10];
    logic [WIDTH-1:0] bank_in [10];

    logic [WIDTH-1:0] data_out;
    logic [3:0]       addr_out;
    logic             valid_out;
    logic             last_out;
    logic             xfer;

    // Gather the bank outputs into an array so the snapshot is one assignment.
    always_comb begin
        bank_in[0] = in0;
        bank_in[1] = in1;
        bank_in[2] = in2;
        bank_in[3] = in3;
        bank_in[4] = in4;
        bank_in[5] = in5;
        bank_in[6] = in6;
        bank_in[7] = in7;
        bank_in[8] = in8;
        bank_in[9] = in9;
    end

    // Next-state, snapshot capture, index advance and stream outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        data_out  = '0;
        addr_out  = '0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = bank_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                data_out  = snap_q[idx_q];
                addr_out  = idx_q;
                last_out  = (idx_q == LAST_IDX);
                xfer      = bus.readyOut;
                if (bus.readyOut) begin
                    if (last_out) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dataOut  = data_out;
    assign bus.addrOut  = addr_out;
    assign bus.validOut = valid_out;
    assign bus.lastOut  = last_out;

    // State, index and snapshot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < 10; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

`ifdef READER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;

    // Accumulator clears on start accept and adds each transferred word.
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + data_out;
        end
    end

    // Checksum register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksumOut = sum_q;
`endif

endmodule
